// File: rtl/cricket_match_ctrl_if.sv
// rtl/cricket_match_ctrl_if.sv - match engine play/ball/display bundle
//
// Purpose : groups the play pulse, ball outcome strobe, team select and all
//           score/status outputs of the match engine.
// Ports   : master drives play, ball_valid, ball_outcome, teamSwitch and
//           observes the display/status outputs; slave is the engine side.
interface cricket_match_ctrl_if #(
    parameter int RUN_W = 9,
    parameter int OV_W  = 5
);
    logic               play;
    logic               ball_valid;
    logic [2:0]         ball_outcome;
    logic               teamSwitch;
    logic [RUN_W-1:0]   disp_runs;
    logic [3:0]         disp_wickets;
    logic [OV_W-1:0]    disp_overs;
    logic [3:0]         disp_balls;
    logic [RUN_W:0]     target;
    logic [2:0]         state;
    logic               inningOver;
    logic               gameOver;
    logic [1:0]         winner;
    logic [15:0]        leds;

    modport master (
        output play, ball_valid, ball_outcome, teamSwitch,
        input  disp_runs, disp_wickets, disp_overs, disp_balls, target,
               state, inningOver, gameOver, winner, leds
    );

    modport slave (
        input  play, ball_valid, ball_outcome, teamSwitch,
        output disp_runs, disp_wickets, disp_overs, disp_balls, target,
               state, inningOver, gameOver, winner, leds
    );
endinterface

// File: rtl/cricket_match_ctrl.sv
// rtl/cricket_match_ctrl.sv - parametrised limited-overs cricket match engine
//
// Purpose : two-innings match FSM with per-team runs/wickets/overs/balls,
//           chase target, result latch and LED status.
// Ports   : clk_fpga - system clock
//           reset    - asynchronous active-low reset (released synchronously)
//           bus      - slave side of cricket_match_ctrl_if (play, ball
//                      strobe/outcome, team select, display and status)
module cricket_match_ctrl #(
    parameter int OVERS          = 20,
    parameter int BALLS_PER_OVER = 6,
    parameter int MAX_WICKETS    = 10,
    parameter int RUN_W          = 9,
    localparam int OV_W          = $clog2(OVERS + 1)
) (
    input  logic                 clk_fpga,
    input  logic                 reset,
    cricket_match_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INN1  = 3'd1,
        S_BREAK = 3'd2,
        S_INN2  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    typedef logic [RUN_W:0] run_ext_t;

    // Reset asserts immediately but is released only after two clock edges
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk_fpga or negedge reset) begin
        if (!reset) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    state_t             state_q,   state_d;
    logic [RUN_W-1:0]   runs_q [2];
    logic [RUN_W-1:0]   runs_d [2];
    logic [3:0]         wkts_q [2];
    logic [3:0]         wkts_d [2];
    logic [OV_W-1:0]    overs_q [2];
    logic [OV_W-1:0]    overs_d [2];
    logic [3:0]         balls_q [2];
    logic [3:0]         balls_d [2];
    logic [RUN_W:0]     target_q,  target_d;
    logic [1:0]         winner_q,  winner_d;

    // Working values for the batting team's ball
    logic               bat;
    run_ext_t           add_runs;
    run_ext_t           run_sum;
    logic               legal;
    logic [RUN_W-1:0]   new_runs;
    logic [3:0]         new_wkts;
    logic [OV_W-1:0]    new_overs;
    logic [3:0]         new_balls;
    logic               chase;
    logic               inn_end;

    always_ff @(posedge clk_fpga or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            runs_q[0]  <= '0;
            runs_q[1]  <= '0;
            wkts_q[0]  <= '0;
            wkts_q[1]  <= '0;
            overs_q[0] <= '0;
            overs_q[1] <= '0;
            balls_q[0] <= '0;
            balls_q[1] <= '0;
            target_q   <= '0;
            winner_q   <= 2'b00;
        end else begin
            state_q    <= state_d;
            runs_q     <= runs_d;
            wkts_q     <= wkts_d;
            overs_q    <= overs_d;
            balls_q    <= balls_d;
            target_q   <= target_d;
            winner_q   <= winner_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        runs_d    = runs_q;
        wkts_d    = wkts_q;
        overs_d   = overs_q;
        balls_d   = balls_q;
        target_d  = target_q;
        winner_d  = winner_q;

        bat       = (state_q == S_INN2);
        legal     = (bus.ball_outcome != 3'd7);

        case (bus.ball_outcome)
            3'd5:    add_runs = run_ext_t'(6);
            3'd6:    add_runs = '0;
            3'd7:    add_runs = run_ext_t'(1);
            default: add_runs = run_ext_t'(bus.ball_outcome);
        endcase

        // One extra bit catches the carry so the counter clamps instead of wrapping
        run_sum  = run_ext_t'(runs_q[bat]) + add_runs;
        new_runs = run_sum[RUN_W] ? {RUN_W{1'b1}} : run_sum[RUN_W-1:0];

        new_wkts = (bus.ball_outcome == 3'd6) ? wkts_q[bat] + 4'd1 : wkts_q[bat];

        new_overs = overs_q[bat];
        new_balls = balls_q[bat];
        if (legal) begin
            if (balls_q[bat] == 4'(BALLS_PER_OVER - 1)) begin
                new_balls = 4'd0;
                new_overs = overs_q[bat] + 1'b1;
            end else begin
                new_balls = balls_q[bat] + 4'd1;
            end
        end

        chase   = (state_q == S_INN2) && (run_ext_t'(new_runs) >= target_q);
        inn_end = (new_wkts == 4'(MAX_WICKETS)) ||
                  ((new_overs == OV_W'(OVERS)) && (new_balls == 4'd0));

        case (state_q)
            S_IDLE: begin
                if (bus.play) begin
                    state_d = S_INN1;
                end
            end
            S_BREAK: begin
                if (bus.play) begin
                    state_d = S_INN2;
                end
            end
            S_INN1, S_INN2: begin
                if (bus.ball_valid) begin
                    runs_d[bat]  = new_runs;
                    wkts_d[bat]  = new_wkts;
                    overs_d[bat] = new_overs;
                    balls_d[bat] = new_balls;
                    if (state_q == S_INN1) begin
                        if (inn_end) begin
                            state_d  = S_BREAK;
                            target_d = run_ext_t'(new_runs) + run_ext_t'(1);
                        end
                    end else if (chase || inn_end) begin
                        state_d = S_DONE;
                        if (new_runs > runs_q[0]) begin
                            winner_d = 2'b10;
                        end else if (new_runs < runs_q[0]) begin
                            winner_d = 2'b01;
                        end else begin
                            winner_d = 2'b11;
                        end
                    end
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    // LED status: state one-hot plus thermometer of the batting team's over
    logic [3:0]  state_onehot;
    logic [11:0] ball_therm;
    logic [3:0]  led_balls;

    always_comb begin
        case (state_q)
            S_IDLE:  state_onehot = 4'b0001;
            S_INN1:  state_onehot = 4'b0010;
            S_BREAK: state_onehot = 4'b0100;
            S_INN2:  state_onehot = 4'b1000;
            default: state_onehot = 4'b0000;
        endcase

        led_balls  = (state_q == S_INN2 || state_q == S_DONE) ? balls_q[1] : balls_q[0];
        ball_therm = '0;
        for (int i = 0; i < 12; i++) begin
            if ((i < BALLS_PER_OVER) && (i < int'(led_balls))) begin
                ball_therm[i] = 1'b1;
            end
        end
    end

    assign bus.disp_runs    = runs_q[bus.teamSwitch];
    assign bus.disp_wickets = wkts_q[bus.teamSwitch];
    assign bus.disp_overs   = overs_q[bus.teamSwitch];
    assign bus.disp_balls   = balls_q[bus.teamSwitch];
    assign bus.target       = target_q;
    assign bus.state        = state_q;
    assign bus.inningOver   = (state_q == S_BREAK) || (state_q == S_DONE);
    assign bus.gameOver     = (state_q == S_DONE);
    assign bus.winner       = winner_q;
    assign bus.leds         = {state_onehot, ball_therm};

endmodule
